expiry_alarm_ctrl: RTL
======================

# expiry_alarm_ctrl

Sequencer around the countdown timer that detects expiry, drives a patterned buzzer and blank-blink request for the display, and terminates the alarm on acknowledge or timeout. It latches the preset at each fresh start so it can re-arm the timer through a reload/start handshake. It sits beside the countdown timer in the application top and consumes the existing 1 ms and 1 s tick enables.

## Interface
- CNT_BITS, 16, width of timer seconds value
- ALARM_TIMEOUT_S, 30, S_CE ticks after which an unacknowledged alarm self-terminates
- BEEP_ON_MS, 100, buzzer-high length of each beep (MS_CE ticks)
- BEEP_PERIOD_MS, 250, beep-to-beep period inside a burst
- BURST_BEEPS, 3, beeps per burst
- BURST_PERIOD_MS, 1000, burst repetition period; must be ≥ BURST_BEEPS*BEEP_PERIOD_MS

Ports:
- CLK  in  1  system clock, single clock domain
- CLR  in  1  reset, asynchronous, active-low
- CE  in  1  global enable; all state updates qualified by CE=1
- MS_CE  in  1  1 ms tick, one CLK cycle wide
- S_CE  in  1  1 s tick, one CLK cycle wide
- SECS  in  CNT_BITS  current timer value in seconds
- IS_RUNNING  in  1  timer running flag
- BTN_ACK  in  1  debounced one-cycle acknowledge/cancel pulse
- ALARM  out  1  high while in ALARM
- BUZZER  out  1  beep pattern output
- DISP_BLANK  out  1  display blank request (blink during alarm)
- RELOAD  out  1  one-cycle pulse: timer loads RELOAD_VAL
- RELOAD_VAL  out  CNT_BITS  latched preset
- START_REQ  out  1  one-cycle pulse: timer starts running

## Operation
- Edge detect: run_q holds IS_RUNNING from the previous CE cycle; rise = IS_RUNNING & ~run_q, fall = ~IS_RUNNING & run_q.
- States: IDLE, ARMED, PAUSED, ALARM, RELOAD, START, WAIT.
- IDLE: rise with SECS≠0 → latch RELOAD_VAL=SECS, go ARMED. Rise with SECS=0 ignored.
- ARMED: fall with SECS=0 → ALARM; fall with SECS≠0 → PAUSED. BTN_ACK ignored.
- PAUSED: rise → ARMED, preset not re-latched; BTN_ACK → IDLE.
- ALARM: exit on BTN_ACK or on the ALARM_TIMEOUT_S-th S_CE counted in ALARM. Both in the same cycle → one exit. Exit target is IDLE, or RELOAD when AUTO_REPEAT_EN is defined.
- RELOAD: RELOAD=1 for exactly one cycle → START.
- START: START_REQ=1 for exactly one cycle → WAIT.
- WAIT: IS_RUNNING=1 → ARMED, with run_q forced to 1 so no false rise is seen; BTN_ACK → IDLE.
- Beep pattern in ALARM: ms_pos counts MS_CE ticks 0..BURST_PERIOD_MS-1 and wraps; beep_pos counts 0..BEEP_PERIOD_MS-1 and wraps. BUZZER = (ms_pos < BURST_BEEPS*BEEP_PERIOD_MS) & (beep_pos < BEEP_ON_MS). DISP_BLANK = ms_pos ≥ BURST_PERIOD_MS/2.
- Both position counters and the timeout counter clear on ALARM entry.
- Outside ALARM: BUZZER=0, DISP_BLANK=0.

## Timing
- All outputs registered.
- Reset values: state IDLE, ALARM=0, BUZZER=0, DISP_BLANK=0, RELOAD=0, START_REQ=0, RELOAD_VAL=0, run_q=0, all counters 0.
- CLR low mid-operation forces reset values immediately and asynchronously, including a beeping BUZZER.
- Expiry fall seen at cycle n → ALARM=1 and BUZZER=1 after edge n+1.
- BTN_ACK at cycle n in ALARM → ALARM=0 and BUZZER=0 after edge n+1.
- Auto-repeat: RELOAD pulses in cycle n+1, START_REQ in n+2.
- Timeout granularity: S_CE is unaligned, so actual alarm length is in (ALARM_TIMEOUT_S-1, ALARM_TIMEOUT_S] s.
- CE=0 freezes all state, counters and outputs. RELOAD and START_REQ still deassert after one cycle.

## Configuration
- AUTO_REPEAT_EN defined: ALARM exit goes through RELOAD → START → WAIT → ARMED, restarting the timer from RELOAD_VAL.
- AUTO_REPEAT_EN undefined: ALARM exit goes to IDLE. RELOAD and START_REQ are tied 0, and the RELOAD, START and WAIT states are not implemented.

## Test plan
- Start with SECS=5 → RELOAD_VAL=5 and ARMED. Simulate countdown to 0 with fall → ALARM=1 next cycle; BUZZER high 100 ms / low 150 ms three times, then low until 1000 ms; DISP_BLANK high for ms_pos 500..999.
- Alarm with no acknowledge, ALARM_TIMEOUT_S=3 → ALARM drops on the 3rd S_CE; non-repeat build returns to IDLE.
- Run SECS=10, fall at SECS=4 → PAUSED. Rise → ARMED with RELOAD_VAL still 10. BTN_ACK in PAUSED → IDLE.
- AUTO_REPEAT_EN build, BTN_ACK in ALARM → RELOAD=1 with RELOAD_VAL=5 one cycle, START_REQ=1 next cycle, then WAIT; IS_RUNNING=1 → ARMED, no re-latch.
- Rise with SECS=0 in IDLE → stays IDLE. BTN_ACK coincident with the timeout S_CE → a single exit. CLR low during beep → BUZZER=0 with no CLK edge.

Source files
------------

// File: rtl/expiry_alarm_ctrl.sv
// Expiry/alarm sequencer beside the countdown timer: buzzer burst pattern, display blink, ack/timeout exit.
// Build macro AUTO_REPEAT_EN: alarm exit reloads and restarts the timer instead of returning to idle.
module expiry_alarm_ctrl #(
    parameter int CNT_BITS        = 16,
    parameter int ALARM_TIMEOUT_S = 30,
    parameter int BEEP_ON_MS      = 100,
    parameter int BEEP_PERIOD_MS  = 250,
    parameter int BURST_BEEPS     = 3,
    parameter int BURST_PERIOD_MS = 1000
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    input  logic                MS_CE,
    input  logic                S_CE,
    input  logic [CNT_BITS-1:0] SECS,
    input  logic                IS_RUNNING,
    input  logic                BTN_ACK,
    output logic                ALARM,
    output logic                BUZZER,
    output logic                DISP_BLANK,
    output logic                RELOAD,
    output logic [CNT_BITS-1:0] RELOAD_VAL,
    output logic                START_REQ
);
    localparam int MS_W = $clog2(BURST_PERIOD_MS + 1);
    localparam int BP_W = $clog2(BEEP_PERIOD_MS + 1);
    localparam int TO_W = $clog2(ALARM_TIMEOUT_S + 1);

    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(BURST_PERIOD_MS - 1);
    localparam logic [MS_W-1:0] BURST_ON = MS_W'(BURST_BEEPS * BEEP_PERIOD_MS);
    localparam logic [MS_W-1:0] MS_HALF  = MS_W'(BURST_PERIOD_MS / 2);
    localparam logic [BP_W-1:0] BP_LAST  = BP_W'(BEEP_PERIOD_MS - 1);
    localparam logic [BP_W-1:0] BEEP_ON  = BP_W'(BEEP_ON_MS);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(ALARM_TIMEOUT_S - 1);

`ifdef AUTO_REPEAT_EN
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PAUSED, S_ALARM, S_RELOAD, S_START, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PAUSED, S_ALARM} state_t;
`endif

    state_t              state;
    logic                run_q;
    logic [CNT_BITS-1:0] reload_val;
    logic [MS_W-1:0]     ms_pos, ms_nxt;
    logic [BP_W-1:0]     beep_pos, beep_nxt;
    logic [TO_W-1:0]     to_cnt;
    logic                alarm_q, buzzer_q, blank_q;
    logic                rise, fall, alarm_exit, buzz_nxt, blank_nxt;

    assign rise       = IS_RUNNING & ~run_q;
    assign fall       = ~IS_RUNNING & run_q;
    assign alarm_exit = BTN_ACK | (S_CE & (to_cnt == TO_LAST));

    // Pattern outputs are registered from the post-tick positions so they track the counters.
    always_comb begin
        ms_nxt   = ms_pos;
        beep_nxt = beep_pos;
        if (MS_CE) begin
            ms_nxt   = (ms_pos == MS_LAST) ? '0 : ms_pos + 1'b1;
            beep_nxt = (beep_pos == BP_LAST) ? '0 : beep_pos + 1'b1;
        end
        buzz_nxt  = (ms_nxt < BURST_ON) & (beep_nxt < BEEP_ON);
        blank_nxt = (ms_nxt >= MS_HALF);
    end

`ifdef AUTO_REPEAT_EN
    logic reload_q, start_q;
    assign RELOAD    = reload_q;
    assign START_REQ = start_q;
`else
    assign RELOAD    = 1'b0;
    assign START_REQ = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= S_IDLE;
            run_q      <= 1'b0;
            reload_val <= '0;
            ms_pos     <= '0;
            beep_pos   <= '0;
            to_cnt     <= '0;
            alarm_q    <= 1'b0;
            buzzer_q   <= 1'b0;
            blank_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            reload_q   <= 1'b0;
            start_q    <= 1'b0;
`endif
        end else begin
`ifdef AUTO_REPEAT_EN
            // Handshake pulses drop after one cycle even while CE holds everything else.
            reload_q <= 1'b0;
            start_q  <= 1'b0;
`endif
            if (CE) begin
                run_q <= IS_RUNNING;
                case (state)
                    S_IDLE: if (rise && SECS != '0) begin
                        reload_val <= SECS;
                        state      <= S_ARMED;
                    end
                    S_ARMED: if (fall) begin
                        if (SECS == '0) begin
                            state    <= S_ALARM;
                            ms_pos   <= '0;
                            beep_pos <= '0;
                            to_cnt   <= '0;
                            alarm_q  <= 1'b1;
                            buzzer_q <= (BURST_ON != '0) && (BEEP_ON != '0);
                            blank_q  <= (MS_HALF == '0);
                        end else begin
                            state <= S_PAUSED;
                        end
                    end
                    S_PAUSED: begin
                        if (rise)         state <= S_ARMED;
                        else if (BTN_ACK) state <= S_IDLE;
                    end
                    S_ALARM: begin
                        if (alarm_exit) begin
                            alarm_q  <= 1'b0;
                            buzzer_q <= 1'b0;
                            blank_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
                            state    <= S_RELOAD;
                            reload_q <= 1'b1;
`else
                            state    <= S_IDLE;
`endif
                        end else begin
                            ms_pos   <= ms_nxt;
                            beep_pos <= beep_nxt;
                            buzzer_q <= buzz_nxt;
                            blank_q  <= blank_nxt;
                            if (S_CE) to_cnt <= to_cnt + 1'b1;
                        end
                    end
`ifdef AUTO_REPEAT_EN
                    S_RELOAD: begin
                        state   <= S_START;
                        start_q <= 1'b1;
                    end
                    S_START: state <= S_WAIT;
                    S_WAIT: begin
                        // Timer already running on entry to ARMED: suppress a false rise.
                        if (IS_RUNNING) begin
                            state <= S_ARMED;
                            run_q <= 1'b1;
                        end else if (BTN_ACK) begin
                            state <= S_IDLE;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ALARM      = alarm_q;
    assign BUZZER     = buzzer_q;
    assign DISP_BLANK = blank_q;
    assign RELOAD_VAL = reload_val;
endmodule
